// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: request/acknowledge and memory-bus bundle between the requesters, the arbiter and the memory
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic inCpuReq;
  logic inCpuRDWR;
  logic [AW-1:0] inCpuAddr;
  logic [DW-1:0] inCpuData;
  logic oCpuAck;
  logic [DW-1:0] oCpuData;
  logic oCpuWait;
  logic inLdReq;
  logic inLdRDWR;
  logic [AW-1:0] inLdAddr;
  logic [DW-1:0] inLdData;
  logic oLdAck;
  logic [DW-1:0] oLdData;
  logic [AW-1:0] oMemAddr;
  logic [DW-1:0] oMemData;
  logic oMemCE;
  logic oMemRDWR;
  logic [DW-1:0] inMemData;
  logic [1:0] oOwner;
  modport slave (
    input inCpuReq, inCpuRDWR, inCpuAddr, inCpuData,
    input inLdReq, inLdRDWR, inLdAddr, inLdData, inMemData,
    output oCpuAck, oCpuData, oCpuWait, oLdAck, oLdData,
    output oMemAddr, oMemData, oMemCE, oMemRDWR, oOwner
  );
  modport master (
    output inCpuReq, inCpuRDWR, inCpuAddr, inCpuData,
    output inLdReq, inLdRDWR, inLdAddr, inLdData, inMemData,
    input oCpuAck, oCpuData, oCpuWait, oLdAck, oLdData,
    input oMemAddr, oMemData, oMemCE, oMemRDWR, oOwner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the CPU and the program loader with a fixed-length access window
// Define MEM_ARB_RR_EN for round-robin arbitration; default is CPU priority with a loader starvation guard
module mem_port_arbiter #(
  parameter int AW = 16,
  parameter int DW = 8,
  parameter int ACC_CYC = 2,
  parameter int MAX_BURST = 4
) (
  input logic inCLK,
  input logic inRST,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state;
  logic [3:0] cycCnt;
  logic winLd;
  logic grantLd;
  logic [AW-1:0] latAddr;
  logic [DW-1:0] latData;
  logic latRDWR;
`ifdef MEM_ARB_RR_EN
  logic lastLd;
  assign grantLd = bus.inLdReq & (~bus.inCpuReq | ~lastLd);
`else
  localparam int BW = $clog2(MAX_BURST + 2);
  logic [BW-1:0] burstCnt;
  assign grantLd = bus.inLdReq & (~bus.inCpuReq | burstCnt == BW'(MAX_BURST));
`endif
  assign bus.oMemAddr = latAddr;
  assign bus.oMemData = latData;
  assign bus.oMemRDWR = latRDWR;
  assign bus.oCpuWait = bus.inCpuReq & ~bus.oCpuAck;
  always_ff @(posedge inCLK) begin
    if (!inRST) begin
      state <= IDLE;
      cycCnt <= '0;
      winLd <= 1'b0;
      latAddr <= '0;
      latData <= '0;
      latRDWR <= 1'b0;
      bus.oMemCE <= 1'b0;
      bus.oOwner <= 2'b00;
      bus.oCpuAck <= 1'b0;
      bus.oLdAck <= 1'b0;
      bus.oCpuData <= '0;
      bus.oLdData <= '0;
`ifdef MEM_ARB_RR_EN
      lastLd <= 1'b1;
`else
      burstCnt <= '0;
`endif
    end else begin
      bus.oCpuAck <= 1'b0;
      bus.oLdAck <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.inCpuReq | bus.inLdReq) begin
            state <= ACCESS;
            cycCnt <= '0;
            winLd <= grantLd;
            latAddr <= grantLd ? bus.inLdAddr : bus.inCpuAddr;
            latData <= grantLd ? bus.inLdData : bus.inCpuData;
            latRDWR <= grantLd ? bus.inLdRDWR : bus.inCpuRDWR;
            bus.oMemCE <= 1'b1;
            bus.oOwner <= grantLd ? 2'b10 : 2'b01;
`ifdef MEM_ARB_RR_EN
            lastLd <= grantLd;
`endif
          end
`ifndef MEM_ARB_RR_EN
          // only CPU wins over a waiting loader extend the streak
          burstCnt <= (bus.inLdReq & bus.inCpuReq & ~grantLd) ? burstCnt + 1'b1 : '0;
`endif
        end
        ACCESS: begin
          cycCnt <= cycCnt + 4'd1;
          if (cycCnt == 4'(ACC_CYC - 1)) begin
            state <= DONE;
            bus.oMemCE <= 1'b0;
            bus.oOwner <= 2'b00;
            bus.oCpuAck <= ~winLd;
            bus.oLdAck <= winLd;
            if (!latRDWR && winLd) bus.oLdData <= bus.inMemData;
            if (!latRDWR && !winLd) bus.oCpuData <= bus.inMemData;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
